// File: rtl/dram_line_responder_pkg.sv
// Shared configuration and types for the tile DRAM line responder.
package dram_line_responder_pkg;

    localparam int GLOBAL_ADDR_BW = 32;
    localparam int DATA_BW        = 16;
    localparam int CACHE_SIZE     = 16;
    localparam int MEM_LINES      = 256;
    localparam int WORD_OFS_BW    = $clog2(CACHE_SIZE);
    localparam int LINE_IDX_BW    = $clog2(MEM_LINES);

    typedef logic [LINE_IDX_BW-1:0]                line_idx_t;
    typedef logic [GLOBAL_ADDR_BW-1:0]             addr_t;
    typedef logic [CACHE_SIZE-1:0][DATA_BW-1:0]    line_t;
    typedef logic [CACHE_SIZE-1:0]                 mask_t;

    // Word address -> line index; word offset and bits above the store wrap away.
    function automatic line_idx_t line_index(input addr_t addr);
        return addr[WORD_OFS_BW +: LINE_IDX_BW];
    endfunction

endpackage

// File: rtl/dram_line_responder_if.sv
// Read-address, read-data and write channels between a tile and its DRAM responder.
interface dram_line_responder_if;
    import dram_line_responder_pkg::*;

    logic  dramra_rdy;
    logic  dramra_ack;
    addr_t i_dramra;
    logic  dramrd_rdy;
    logic  dramrd_ack;
    line_t o_dramrd;
    logic  dramw_rdy;
    logic  dramw_ack;
    addr_t i_dramwa;
    line_t i_dramwd;
    mask_t i_dramw_mask;

    modport master (
        output dramra_rdy, i_dramra, dramrd_ack,
        output dramw_rdy, i_dramwa, i_dramwd, i_dramw_mask,
        input  dramra_ack, dramrd_rdy, o_dramrd, dramw_ack
    );

    modport slave (
        input  dramra_rdy, i_dramra, dramrd_ack,
        input  dramw_rdy, i_dramwa, i_dramwd, i_dramw_mask,
        output dramra_ack, dramrd_rdy, o_dramrd, dramw_ack
    );

endinterface

// File: rtl/dram_line_responder_fifo.sv
// Small register FIFO with rdy/ack handshakes on both sides; reset clears the storage
// so the head reads as zero until the first push.
module dram_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_rdy,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_rdy,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ack   = in_rdy & (count_reg != CW'(DEPTH));
    assign push     = in_ack;
    assign out_rdy  = (count_reg != '0);
    assign pop      = out_rdy & out_ack;
    assign out_data = store_reg[rd_ptr_reg];

    // Pointer/occupancy bookkeeping and storage writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) store_reg[i] <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                store_reg[wr_ptr_reg] <= in_data;
                wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/dram_line_responder.sv
// Memory-side responder: in-order line reads with fixed latency and credit-limited
// result buffering, plus masked line writes into a single-ported line store.
module dram_line_responder
    import dram_line_responder_pkg::*;
#(
    parameter int RQ_DEPTH = 4,
    parameter int RD_LAT   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dram_line_responder_if.slave  bus
);
    localparam int RB_DEPTH = RD_LAT + 1;
    localparam int CRW      = $clog2(RB_DEPTH + 1);

    logic                 run_reg;
    logic                 rq_in_ack;
    logic                 rq_rdy;
    line_idx_t            rq_head;
    logic                 issue;
    logic                 rd_xfer;
    logic                 wr_en;
    line_idx_t            wr_idx;
    logic [CRW-1:0]       credits_reg;
    line_t                arr_line;
    logic                 arr_valid_reg;
    line_t                exit_line;
    logic                 exit_valid;
    logic                 rb_in_ack;
    logic                 rb_rdy;
    logic [$bits(line_t)-1:0] rb_out;

    // Keeps every ack low while reset is applied and for the first cycle after it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) run_reg <= 1'b0;
        else          run_reg <= 1'b1;
    end

    dram_resp_fifo #(.WIDTH(LINE_IDX_BW), .DEPTH(RQ_DEPTH)) u_read_queue (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .in_rdy   (bus.dramra_rdy & run_reg),
        .in_ack   (rq_in_ack),
        .in_data  (line_index(bus.i_dramra)),
        .out_rdy  (rq_rdy),
        .out_ack  (issue),
        .out_data (rq_head)
    );

    // A read may only issue when its result is guaranteed a slot in the result buffer.
    assign issue          = rq_rdy & (credits_reg < CRW'(RB_DEPTH));
    assign rd_xfer        = rb_rdy & bus.dramrd_ack;
    assign bus.dramra_ack = rq_in_ack;
    // Writes wait for an empty read queue, so they never share the array port with an issue
    // and every previously accepted read has already sampled the old contents.
    assign bus.dramw_ack  = bus.dramw_rdy & run_reg & ~rq_rdy & ~issue;
    assign wr_en          = bus.dramw_ack;
    assign wr_idx         = line_index(bus.i_dramwa);

    genvar gi;
    generate
        for (gi = 0; gi < CACHE_SIZE; gi++) begin : g_lane
            logic [DATA_BW-1:0] lane_mem [MEM_LINES];

            // One RAM per word lane gives natural per-word write enables.
            always_ff @(posedge i_clk) begin
                if (wr_en && bus.i_dramw_mask[gi]) lane_mem[wr_idx] <= bus.i_dramwd[gi];
            end

            if (RD_LAT == 1) begin : g_async
                assign arr_line[gi] = lane_mem[rq_head];
            end else begin : g_sync
                logic [DATA_BW-1:0] rd_word_reg;
                // Registered read port, first stage of the read pipeline.
                always_ff @(posedge i_clk) begin
                    if (issue) rd_word_reg <= lane_mem[rq_head];
                end
                assign arr_line[gi] = rd_word_reg;
            end
        end
    endgenerate

    // Credits count reads issued but not yet handed to the requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_reg   <= '0;
            arr_valid_reg <= 1'b0;
        end else begin
            credits_reg   <= credits_reg + CRW'(issue) - CRW'(rd_xfer);
            arr_valid_reg <= issue;
        end
    end

    // The result buffer write is the last of the RD_LAT stages after issue.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign exit_valid = issue;
            assign exit_line  = arr_line;
        end else if (RD_LAT == 2) begin : g_lat2
            assign exit_valid = arr_valid_reg;
            assign exit_line  = arr_line;
        end else begin : g_latn
            logic [RD_LAT-3:0] dly_valid_reg;
            line_t             dly_line_reg [RD_LAT-2];

            // Valid bits of the delay stages; dropped on reset to abandon in-flight reads.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    dly_valid_reg <= '0;
                end else begin
                    dly_valid_reg[0] <= arr_valid_reg;
                    for (int i = 1; i < RD_LAT - 2; i++) dly_valid_reg[i] <= dly_valid_reg[i-1];
                end
            end

            // Data follows the valid bits without reset.
            always_ff @(posedge i_clk) begin
                dly_line_reg[0] <= arr_line;
                for (int i = 1; i < RD_LAT - 2; i++) dly_line_reg[i] <= dly_line_reg[i-1];
            end

            assign exit_valid = dly_valid_reg[RD_LAT-3];
            assign exit_line  = dly_line_reg[RD_LAT-3];
        end
    endgenerate

    dram_resp_fifo #(.WIDTH($bits(line_t)), .DEPTH(RB_DEPTH)) u_result_buf (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .in_rdy   (exit_valid),
        .in_ack   (rb_in_ack),
        .in_data  (exit_line),
        .out_rdy  (rb_rdy),
        .out_ack  (bus.dramrd_ack),
        .out_data (rb_out)
    );

    assign bus.dramrd_rdy = rb_rdy;
    assign bus.o_dramrd   = rb_out;

endmodule

// File: tb/tb_dram_line_responder.sv
// Self-checking bench for dram_line_responder: directed scenarios plus random traffic,
// checked against a line-store model and an in-order response queue.
module tb_dram_line_responder;
    import dram_line_responder_pkg::*;

    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_line_responder_if bus();

    dram_line_responder #(.RQ_DEPTH(4), .RD_LAT(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    logic  w_x, ra_x, rd_x, rdy_seen;
    logic [DATA_BW-1:0] model_mem [MEM_LINES][CACHE_SIZE];
    line_t exp_q [$];
    line_t got_q [$];
    int    got_cyc_q [$];

    function automatic int line_of(input addr_t a);
        return int'((a / CACHE_SIZE) % MEM_LINES);
    endfunction

    function automatic line_t model_line(input int idx);
        line_t l;
        for (int c = 0; c < CACHE_SIZE; c++) l[c] = model_mem[idx][c];
        return l;
    endfunction

    function automatic addr_t rand_addr(input int line);
        return addr_t'(line * CACHE_SIZE + int'($urandom_range(0, CACHE_SIZE - 1)))
             + addr_t'($urandom_range(0, 7)) * addr_t'(MEM_LINES * CACHE_SIZE);
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int c = 0; c < CACHE_SIZE; c++) l[c] = DATA_BW'($urandom);
        return l;
    endfunction

    task automatic idle_inputs();
        bus.dramra_rdy   = 1'b0;
        bus.i_dramra     = '0;
        bus.dramrd_ack   = 1'b0;
        bus.dramw_rdy    = 1'b0;
        bus.i_dramwa     = '0;
        bus.i_dramwd     = '0;
        bus.i_dramw_mask = '0;
    endtask

    // One clock cycle: sample handshakes just after the inputs settle, update the model
    // (write before read when both happen), then advance to the next falling edge.
    task automatic step();
        #1;
        w_x      = bus.dramw_rdy & bus.dramw_ack;
        ra_x     = bus.dramra_rdy & bus.dramra_ack;
        rd_x     = bus.dramrd_rdy & bus.dramrd_ack;
        rdy_seen = bus.dramrd_rdy;
        if (rd_x) begin
            got_q.push_back(bus.o_dramrd);
            got_cyc_q.push_back(cyc);
        end
        if (w_x)
            for (int c = 0; c < CACHE_SIZE; c++)
                if (bus.i_dramw_mask[c]) model_mem[line_of(bus.i_dramwa)][c] = bus.i_dramwd[c];
        if (ra_x) exp_q.push_back(model_line(line_of(bus.i_dramra)));
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_write(input addr_t a, input line_t d, input mask_t m);
        int n = 0;
        bus.i_dramwa = a; bus.i_dramwd = d; bus.i_dramw_mask = m; bus.dramw_rdy = 1'b1;
        do begin step(); n++; end while (!w_x && n < 20);
        bus.dramw_rdy = 1'b0;
        if (!w_x) begin
            checks++; errors++;
            $display("FAIL write_accept_timeout addr %h: no ack seen, required ack within 20 cycles", a);
        end
    endtask

    task automatic do_read(input addr_t a);
        int n = 0;
        bus.i_dramra = a; bus.dramra_rdy = 1'b1;
        do begin step(); n++; end while (!ra_x && n < 20);
        bus.dramra_rdy = 1'b0;
        if (!ra_x) begin
            checks++; errors++;
            $display("FAIL read_accept_timeout addr %h: no ack seen, required ack within 20 cycles", a);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.dramrd_ack = 1'b1;
        while (got_q.size() < exp_q.size() && n < 200) begin step(); n++; end
        if (got_q.size() != exp_q.size()) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d responses, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.dramra_rdy = 1'b1; bus.dramw_rdy = 1'b1; bus.dramrd_ack = 1'b1;
        bus.i_dramra = addr_t'($urandom); bus.i_dramwa = addr_t'($urandom);
        bus.i_dramwd = rand_line(); bus.i_dramw_mask = '1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.dramra_ack !== 1'b0) begin errors++; $display("FAIL reset_dramra_ack: got %b required 0", bus.dramra_ack); end
        checks++; if (bus.dramw_ack !== 1'b0) begin errors++; $display("FAIL reset_dramw_ack: got %b required 0", bus.dramw_ack); end
        checks++; if (bus.dramrd_rdy !== 1'b0) begin errors++; $display("FAIL reset_dramrd_rdy: got %b required 0", bus.dramrd_rdy); end
        checks++; if (bus.o_dramrd !== line_t'(0)) begin errors++; $display("FAIL reset_o_dramrd: got %h required 0", bus.o_dramrd); end
        $display("reset: acks=%b%b rdy=%b", bus.dramra_ack, bus.dramw_ack, bus.dramrd_rdy);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
    endtask

    task automatic test_fill();
        for (int l = 0; l < MEM_LINES; l++) do_write(rand_addr(l), rand_line(), '1);
        $display("fill: %0d lines written", MEM_LINES);
    endtask

    task automatic test_latency();
        line_t cnt, g, e;
        int n = 0;
        for (int i = 0; i < CACHE_SIZE; i++) cnt[i] = DATA_BW'(i);
        do_write(addr_t'(5 * CACHE_SIZE), cnt, '1);
        bus.dramrd_ack = 1'b0;
        do_read(addr_t'(5 * CACHE_SIZE));
        rdy_seen = 1'b0;
        while (!rdy_seen && n < 20) begin step(); n++; end
        checks++;
        if (n !== LAT + 1 || !rdy_seen) begin
            errors++; $display("FAIL read_latency: got %0d cycles, required %0d", n, LAT + 1);
        end
        drain();
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL latency_data_model: got %h required %h", g, e); end
            checks++; if (g !== cnt) begin errors++; $display("FAIL latency_data_counting: got %h required %h", g, cnt); end
            $display("latency: %0d cycles data=%h", n, g);
        end
    endtask

    task automatic test_mask();
        line_t aa, want, g, e;
        for (int i = 0; i < CACHE_SIZE; i++) begin
            aa[i]   = 16'hAAAA;
            want[i] = (i < 8) ? 16'hAAAA : DATA_BW'(i);
        end
        do_write(addr_t'(5 * CACHE_SIZE), aa, mask_t'(16'h00FF));
        do_write(addr_t'(5 * CACHE_SIZE), rand_line(), '0);
        do_read(addr_t'(5 * CACHE_SIZE));
        drain();
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL mask_data_model: got %h required %h", g, e); end
            checks++; if (g !== want) begin errors++; $display("FAIL mask_partial_line: got %h required %h", g, want); end
            $display("mask: line5=%h", g);
        end
    endtask

    task automatic test_backpressure();
        int next = 0;
        int n = 0;
        line_t g, e;
        got_cyc_q.delete();
        bus.dramrd_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.i_dramra = addr_t'(next * CACHE_SIZE); bus.dramra_rdy = 1'b1;
            step();
            if (ra_x) next++;
        end
        checks++; if (next !== 8) begin errors++; $display("FAIL backpressure_accepts: got %0d required 8", next); end
        checks++; if (ra_x !== 1'b0) begin errors++; $display("FAIL backpressure_ack_low: got %b required 0", ra_x); end
        bus.dramrd_ack = 1'b1;
        while (next < 12 && n < 100) begin
            bus.i_dramra = addr_t'(next * CACHE_SIZE); bus.dramra_rdy = 1'b1;
            step(); n++;
            if (ra_x) next++;
        end
        bus.dramra_rdy = 1'b0;
        drain();
        for (int i = 0; i < 12 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL backpressure_order %0d: got %h required %h", i, g, e); end
            $display("backpressure: line %0d returned %h", i, g);
        end
        checks++;
        if (got_cyc_q.size() != 12 || got_cyc_q[11] - got_cyc_q[0] != 11) begin
            errors++;
            $display("FAIL backpressure_rate: got %0d responses over %0d cycles, required 12 over 12",
                     got_cyc_q.size(), (got_cyc_q.size() > 0) ? got_cyc_q[$] - got_cyc_q[0] + 1 : 0);
        end
    endtask

    task automatic test_write_blocked();
        line_t old_line, g;
        int n = 0;
        old_line = model_line(20);
        bus.dramrd_ack = 1'b1;
        do_read(addr_t'(20 * CACHE_SIZE));
        bus.i_dramra = addr_t'(20 * CACHE_SIZE); bus.dramra_rdy = 1'b1;
        bus.i_dramwa = addr_t'(20 * CACHE_SIZE); bus.i_dramwd = rand_line();
        bus.i_dramw_mask = '1; bus.dramw_rdy = 1'b1;
        step();
        bus.dramra_rdy = 1'b0;
        checks++; if ({ra_x, w_x} !== 2'b10) begin errors++; $display("FAIL blocked_first_cycle: got ra/w=%b%b required 10", ra_x, w_x); end
        while (!w_x && n < 20) begin step(); n++; end
        bus.dramw_rdy = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL blocked_write_wait: got %0d cycles required 2", n); end
        drain();
        for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
            g = got_q.pop_front(); void'(exp_q.pop_front());
            checks++; if (g !== old_line) begin errors++; $display("FAIL blocked_old_data %0d: got %h required %h", i, g, old_line); end
            $display("write_blocked: read %0d data=%h", i, g);
        end
    endtask

    task automatic test_same_cycle();
        line_t nl, g, e;
        nl = rand_line();
        bus.dramrd_ack = 1'b1;
        bus.i_dramra = rand_addr(30); bus.dramra_rdy = 1'b1;
        bus.i_dramwa = rand_addr(30); bus.i_dramwd = nl; bus.i_dramw_mask = '1; bus.dramw_rdy = 1'b1;
        step();
        bus.dramra_rdy = 1'b0; bus.dramw_rdy = 1'b0;
        checks++; if ({ra_x, w_x} !== 2'b11) begin errors++; $display("FAIL same_cycle_accept: got ra/w=%b%b required 11", ra_x, w_x); end
        drain();
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== nl) begin errors++; $display("FAIL same_cycle_new_data: got %h required %h", g, nl); end
            checks++; if (g !== e) begin errors++; $display("FAIL same_cycle_model: got %h required %h", g, e); end
            $display("same_cycle: data=%h", g);
        end
    endtask

    task automatic test_reset_midflight();
        int cnt = 0;
        line_t g, e;
        bus.dramrd_ack = 1'b0;
        do_read(addr_t'(40 * CACHE_SIZE));
        do_read(addr_t'(41 * CACHE_SIZE));
        do_read(addr_t'(42 * CACHE_SIZE));
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        exp_q.delete(); got_q.delete();
        bus.dramrd_ack = 1'b1;
        repeat (10) begin step(); if (rdy_seen) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL midflight_no_rdy: got %0d rdy cycles required 0", cnt); end
        do_read(addr_t'(41 * CACHE_SIZE));
        drain();
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL midflight_retained: got %h required %h", g, e); end
            $display("reset_midflight: line41=%h", g);
        end
    endtask

    task automatic test_random();
        line_t g, e;
        int k = 0;
        for (int i = 0; i < 400; i++) begin
            bus.dramra_rdy   = 1'($urandom_range(0, 1));
            bus.i_dramra     = rand_addr(int'($urandom_range(0, 15)));
            bus.dramw_rdy    = ($urandom_range(0, 2) == 0);
            bus.i_dramwa     = rand_addr(int'($urandom_range(0, 15)));
            bus.i_dramwd     = rand_line();
            bus.i_dramw_mask = mask_t'($urandom);
            bus.dramrd_ack   = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();
        drain();
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL random_read %0d: got %h required %h", k, g, e); end
            $display("random: read %0d data=%h", k, g);
            k++;
        end
        repeat (8) step();
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL random_extra: got %0d extra responses required 0", got_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_latency();
        test_mask();
        test_backpressure();
        test_write_blocked();
        test_same_cycle();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
